gerenciador_vidas: RTL and testbench
====================================

Name: gerenciador_vidas

Overview:
- Remaining-lives manager for the game datapath. It is the down-counting counterpart of the saturating up-counting lives-lost counter.
- Loads an initial life count and decrements once per detected hit, with a post-hit invulnerability window.
- Flags game over when the count reaches 0. Outputs feed the display decoders and the main game FSM.

Parameters:
- WIDTH, 3, bit width of the lives count.
- VIDAS_INICIAIS, 3, count loaded at reset/start. Legal range 1..2^WIDTH-1.
- INVULN_CICLOS, 4, number of clock cycles invulneravel stays high after a hit. Legal range 1..255 (8-bit timer).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  level; when 1 on a clock edge, (re)starts a game
- hit    input  1  level; rising edge (registered detection) = player hit
- vidas  output WIDTH  remaining lives, registered
- game_over  output 1  high while in state FIM, registered
- invulneravel  output 1  high while in state INVULNERAVEL, registered
- perdeu_vida  output 1  one-cycle pulse on each accepted hit, registered

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). No other clock or async path.
- Reset values: state=OCIOSO, vidas=VIDAS_INICIAIS, game_over=0, invulneravel=0, perdeu_vida=0, timer=0, hit_prev=0.
- Edge detect: hit_prev <= hit every cycle, in all states. hit_edge = hit & ~hit_prev.
  - A hit held high generates exactly one edge.
- Priority per edge: reset > start > hit_edge > timer.
- start (any state): vidas <= VIDAS_INICIAIS, timer <= 0, state <= JOGANDO, perdeu_vida <= 0. A hit_edge in the same cycle is discarded.
- OCIOSO: waits for start. hit is ignored.
- JOGANDO, on hit_edge:
  - perdeu_vida <= 1 for one cycle.
  - vidas <= vidas-1.
  - If vidas was 1: state <= FIM, game_over <= 1.
  - Otherwise: state <= INVULNERAVEL, timer <= INVULN_CICLOS-1.
- INVULNERAVEL:
  - hit_edge is ignored (no decrement, no pulse).
  - When timer==0: state <= JOGANDO. Otherwise timer <= timer-1.
  - invulneravel is therefore high for exactly INVULN_CICLOS cycles.
- FIM:
  - vidas holds 0, hit is ignored. Only start or reset leaves.
  - vidas never underflows.
- Latency: the hit edge is sampled at edge N (hit=1, hit_prev=0). vidas, perdeu_vida and state change at the same edge N and are visible after it.
- Reset mid-game (any state): returns to the reset values on the next edge.
- Hit rising exactly on the cycle invulnerability ends: ignored if the edge is sampled while state=INVULNERAVEL.

Optional Feature:
- Macro: GERENCIADOR_VIDAS_BONUS_EN.
- Defined:
  - Adds input port bonus (1 bit), with its own registered edge detect.
  - bonus_edge in JOGANDO or INVULNERAVEL: vidas <= vidas+1, saturating at 2^WIDTH-1.
  - bonus_edge together with an accepted hit_edge in JOGANDO: vidas is unchanged, perdeu_vida still pulses, and the FSM enters INVULNERAVEL (never FIM).
  - bonus is ignored in OCIOSO and FIM, and when start is high.
- Undefined: no bonus port; behaviour exactly as above.

Test Plan:
- Reset, then start=1 for 1 cycle -> vidas=3, game_over=0, invulneravel=0, state JOGANDO.
- One hit pulse -> vidas=2, perdeu_vida high 1 cycle, invulneravel high exactly 4 cycles. A second hit edge inside the window leaves vidas=2.
- Hit held high for 20 cycles -> a single decrement (vidas 3->2), with no retrigger after invulnerability ends.
- Three spaced hits -> vidas 3,2,1,0. The third hit sets game_over=1 with no invulnerability. Further hits keep vidas=0. start -> vidas=3, game_over=0.
- start and hit edge in the same cycle while vidas=1 -> vidas=3, no perdeu_vida. Reset asserted during INVULNERAVEL -> next edge vidas=3, state OCIOSO, invulneravel=0.
- With GERENCIADOR_VIDAS_BONUS_EN, at vidas=7 (WIDTH=3): bonus -> stays 7. At vidas=1, hit+bonus in the same cycle -> vidas=1, perdeu_vida=1, invulneravel=1, game_over=0.

Source files
------------

// File: rtl/gerenciador_vidas.sv
// Remaining-lives manager: loads a life count, decrements once per hit edge, and keeps a post-hit invulnerability window.
// Optional extra-life input is enabled by defining GERENCIADOR_VIDAS_BONUS_EN.
//
// state        | meaning
// OCIOSO       | idle after reset, waiting for start
// JOGANDO      | playing, hit edges are accepted
// INVULNERAVEL | post-hit window, hit edges are ignored
// FIM          | game over, lives held at 0 until start
module gerenciador_vidas #(
  parameter int WIDTH          = 3,
  parameter int VIDAS_INICIAIS = 3,
  parameter int INVULN_CICLOS  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hit,
`ifdef GERENCIADOR_VIDAS_BONUS_EN
  input  logic             bonus,
`endif
  output logic [WIDTH-1:0] vidas,
  output logic             game_over,
  output logic             invulneravel,
  output logic             perdeu_vida
);

  localparam logic [WIDTH-1:0] VIDAS_INI   = WIDTH'(VIDAS_INICIAIS);
  localparam logic [WIDTH-1:0] VIDAS_MAX   = '1;
  localparam logic [WIDTH-1:0] VIDA_UM     = WIDTH'(1);
  localparam logic [7:0]       TIMER_CARGA = 8'(INVULN_CICLOS - 1);

  typedef enum logic [1:0] {OCIOSO, JOGANDO, INVULNERAVEL, FIM} estado_t;

  estado_t          estado;
  logic [7:0]       timer;
  logic             hit_prev;
  logic             hit_edge;
  logic             bonus_edge;
  logic [WIDTH-1:0] vidas_mais;

  assign hit_edge = hit & ~hit_prev;

`ifdef GERENCIADOR_VIDAS_BONUS_EN
  logic bonus_prev;
  assign bonus_edge = bonus & ~bonus_prev;

  always_ff @(posedge clock) begin
    if (reset) bonus_prev <= 1'b0;
    else       bonus_prev <= bonus;
  end
`else
  assign bonus_edge = 1'b0;
`endif

  assign vidas_mais = (vidas == VIDAS_MAX) ? vidas : vidas + VIDA_UM;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      vidas        <= VIDAS_INI;
      game_over    <= 1'b0;
      invulneravel <= 1'b0;
      perdeu_vida  <= 1'b0;
      timer        <= 8'd0;
      hit_prev     <= 1'b0;
    end else begin
      hit_prev    <= hit;
      perdeu_vida <= 1'b0;
      if (start) begin
        // start wins over any simultaneous hit or bonus edge
        estado       <= JOGANDO;
        vidas        <= VIDAS_INI;
        timer        <= 8'd0;
        game_over    <= 1'b0;
        invulneravel <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: ;
          JOGANDO: begin
            if (hit_edge) begin
              perdeu_vida <= 1'b1;
              if (bonus_edge) begin
                // hit and bonus cancel out, but the window still starts
                estado       <= INVULNERAVEL;
                invulneravel <= 1'b1;
                timer        <= TIMER_CARGA;
              end else if (vidas == VIDA_UM) begin
                vidas     <= '0;
                estado    <= FIM;
                game_over <= 1'b1;
              end else begin
                vidas        <= vidas - VIDA_UM;
                estado       <= INVULNERAVEL;
                invulneravel <= 1'b1;
                timer        <= TIMER_CARGA;
              end
            end else if (bonus_edge) begin
              vidas <= vidas_mais;
            end
          end
          INVULNERAVEL: begin
            if (bonus_edge) vidas <= vidas_mais;
            if (timer == 8'd0) begin
              estado       <= JOGANDO;
              invulneravel <= 1'b0;
            end else begin
              timer <= timer - 8'd1;
            end
          end
          FIM: vidas <= '0;
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gerenciador_vidas.sv
// Self-checking bench for gerenciador_vidas: directed scenarios plus random stimulus against a
// behavioural lives/invulnerability model.
module tb_gerenciador_vidas;

  localparam int WIDTH = 3;
  localparam int VI    = 3;
  localparam int INV   = 4;
  localparam int VMAX  = (1 << WIDTH) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             hit   = 1'b0;
  logic             bonus = 1'b0;
  logic [WIDTH-1:0] vidas;
  logic             game_over;
  logic             invulneravel;
  logic             perdeu_vida;

  int n_cmp = 0;
  int n_err = 0;

  // model: lives count, remaining invulnerable cycles, playing/over flags
  int m_lives   = VI;
  int m_inv     = 0;
  bit m_playing = 0;
  bit m_over    = 0;
  bit m_pulse   = 0;
  bit m_hprev   = 0;
  bit m_bprev   = 0;

  gerenciador_vidas #(.WIDTH(WIDTH), .VIDAS_INICIAIS(VI), .INVULN_CICLOS(INV)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .hit(hit),
`ifdef GERENCIADOR_VIDAS_BONUS_EN
    .bonus(bonus),
`endif
    .vidas(vidas),
    .game_over(game_over),
    .invulneravel(invulneravel),
    .perdeu_vida(perdeu_vida)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hedge, bedge;
    hedge = hit && !m_hprev;
    bedge = bonus && !m_bprev;
    if (reset) begin
      m_lives = VI; m_inv = 0; m_playing = 0; m_over = 0; m_pulse = 0;
      m_hprev = 0; m_bprev = 0;
      return;
    end
    m_pulse = 0;
    if (start) begin
      m_lives = VI; m_inv = 0; m_playing = 1; m_over = 0;
    end else if (m_playing) begin
      if (m_inv > 0) begin
        if (bedge && m_lives < VMAX) m_lives++;
        m_inv--;
      end else if (hedge) begin
        m_pulse = 1;
        if (bedge) m_inv = INV;
        else begin
          m_lives--;
          if (m_lives == 0) begin m_over = 1; m_playing = 0; end
          else m_inv = INV;
        end
      end else if (bedge && m_lives < VMAX) begin
        m_lives++;
      end
    end
    m_hprev = hit;
    m_bprev = bonus;
  endtask

  // drive at negedge, clock, update model, compare at next negedge
  task automatic tick(input bit r, input bit s, input bit h, input bit b);
    reset = r; start = s; hit = h;
`ifdef GERENCIADOR_VIDAS_BONUS_EN
    bonus = b;
`else
    bonus = 1'b0;
    if (b) begin end
`endif
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("vidas", int'(vidas), m_lives);
    check("game_over", int'(game_over), int'(m_over));
    check("invulneravel", int'(invulneravel), int'(m_inv > 0));
    check("perdeu_vida", int'(perdeu_vida), int'(m_pulse));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clock);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("reset_vidas", int'(vidas), 3);
    check("reset_game_over", int'(game_over), 0);
    check("reset_invuln", int'(invulneravel), 0);
    tick(0, 0, 1, 0);
    check("idle_ignores_hit", int'(vidas), 3);
    tick(0, 1, 0, 0);
    check("start_vidas", int'(vidas), 3);

    // single hit and the invulnerability window length
    tick(0, 0, 1, 0);
    check("hit_vidas", int'(vidas), 2);
    check("hit_pulse", int'(perdeu_vida), 1);
    check("hit_invuln", int'(invulneravel), 1);
    tick(0, 0, 0, 0);
    check("pulse_one_cycle", int'(perdeu_vida), 0);
    tick(0, 0, 1, 0);
    check("hit_in_window", int'(vidas), 2);
    tick(0, 0, 0, 0);
    check("window_cycle4", int'(invulneravel), 1);
    tick(0, 0, 0, 0);
    check("window_end", int'(invulneravel), 0);

    // held hit gives one decrement only
    tick(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    check("held_hit", int'(vidas), 2);

    // run to game over
    tick(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0);
      check("spaced_hit", int'(vidas), 2 - k);
      idle(6);
    end
    check("over_flag", int'(game_over), 1);
    check("over_no_invuln", int'(invulneravel), 0);
    tick(0, 0, 1, 0);
    check("over_hold", int'(vidas), 0);
    tick(0, 1, 0, 0);
    check("restart_vidas", int'(vidas), 3);
    check("restart_over", int'(game_over), 0);

    // start beats hit at vidas=1
    tick(0, 0, 1, 0); idle(6);
    tick(0, 0, 1, 0); idle(6);
    check("at_one", int'(vidas), 1);
    tick(0, 1, 1, 0);
    check("start_hit_vidas", int'(vidas), 3);
    check("start_hit_pulse", int'(perdeu_vida), 0);
    idle(2);
    tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    check("reset_mid_vidas", int'(vidas), 3);
    check("reset_mid_invuln", int'(invulneravel), 0);
    tick(0, 0, 1, 0);
    check("reset_mid_idle", int'(vidas), 3);

`ifdef GERENCIADOR_VIDAS_BONUS_EN
    tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin tick(0, 0, 0, 1); tick(0, 0, 0, 0); end
    check("bonus_saturate", int'(vidas), 7);
    for (int i = 0; i < 6; i++) begin tick(0, 0, 1, 0); idle(6); end
    check("bonus_at_one", int'(vidas), 1);
    tick(0, 0, 1, 1);
    check("hit_bonus_vidas", int'(vidas), 1);
    check("hit_bonus_pulse", int'(perdeu_vida), 1);
    check("hit_bonus_invuln", int'(invulneravel), 1);
    check("hit_bonus_over", int'(game_over), 0);
    idle(6);
`endif

    // random phase
    for (int i = 0; i < 4000; i++) begin
      bit r, s, h, b;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 59) == 0);
      h = ($urandom_range(0, 3) == 0) ? ~hit : hit;
      b = ($urandom_range(0, 5) == 0) ? ~bonus : bonus;
      tick(r, s, h, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
